decoupler: RTL and testbench
============================

DECOUPLER -- requirements
Module: decoupler

Interface
REQ-001 Parameter P_WIDTH, default 32, element width in bits.
REQ-002 Parameter P_DEPTH, default 16, input buffer depth in words; power of two, at least 2.
REQ-003 i_clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_data  input  2*P_WIDTH  coupled word {second, first}; first in bits [P_WIDTH-1:0].
REQ-006 i_enq  input  1  write i_data into the input buffer this edge.
REQ-007 o_full  output  1  input buffer holds P_DEPTH words.
REQ-008 o_data  output  P_WIDTH  current element; valid while o_empty=0.
REQ-009 i_deq  input  1  consume o_data this edge.
REQ-010 o_empty  output  1  no element presented.

Function
REQ-011 The block SHALL unpack each word into a stream of elements in the order first, then second; an element value of 0 is a stream terminator.
REQ-012 The input buffer SHALL be a circular FIFO of P_DEPTH words with wrap-around read/write pointers and a full/empty distinction via an extra pointer bit.
REQ-013 An i_enq while o_full=1 SHALL be ignored, including when i_deq pops in the same edge; buffer contents SHALL remain unchanged.
REQ-014 An i_deq while o_empty=1 SHALL be ignored.
REQ-015 FSM states: IDLE (nothing presented), LOW (presenting first), HIGH (presenting second).
REQ-016 IDLE: if buffer non-empty, pop one word into the hold register and go to LOW; else stay.
REQ-017 LOW with i_deq: if first != 0, go to HIGH; if first == 0, discard second and load next word (LOW) or go to IDLE.
REQ-018 HIGH with i_deq: load next word and go to LOW if buffer non-empty, else go to IDLE; no bubble between words.
REQ-019 LOW/HIGH without i_deq SHALL hold state and o_data stable.
REQ-020 o_data SHALL equal first in LOW, second in HIGH, 0 in IDLE; o_empty SHALL be 1 exactly in IDLE.
REQ-021 Latency: a word written at edge N into an empty block SHALL present its first element after edge N+1.
REQ-022 Simultaneous i_enq and a buffer pop on one edge SHALL both take effect; occupancy unchanged.
REQ-023 Sustained throughput SHALL be one element per cycle when i_deq is held high.

Reset
REQ-024 While i_rst_n=0: pointers cleared, buffer empty, state IDLE, hold register 0, o_data=0, o_empty=1, o_full=0.
REQ-025 Reset asserted mid-word SHALL discard the buffered words and the held word; no partial element SHALL appear after release.
REQ-026 The first i_enq SHALL be accepted on the first rising edge after i_rst_n rises.

Configuration
REQ-027 Macro DECOUPLER_TERM_COUNT_EN, when defined, SHALL add output o_term_count (16 bits), incremented on each dequeued element equal to 0, wrapping at 2^16, and cleared by reset.
REQ-028 Without DECOUPLER_TERM_COUNT_EN, o_term_count and its counter SHALL NOT exist; all other behaviour is identical.

Verification
REQ-029 Reset release, enq {0x2,0x1} at edge 1, i_deq high -> o_data 0x1 after edge 2, 0x2 after edge 3, o_empty=1 after edge 4.
REQ-030 Enq {0x5,0x0} then {0x4,0x3}, i_deq high -> element stream 0x0, 0x3, 0x4; 0x5 never appears; term count 1 if enabled.
REQ-031 Enq P_DEPTH+2 words with i_deq low -> o_full=1 after the P_DEPTH-th buffered word; excess words dropped; draining yields exactly the accepted words in order across pointer wrap.
REQ-032 Full buffer, i_enq and i_deq on the same edge the HIGH element pops -> new word not stored, o_full stays 1 for one more cycle then drops.
REQ-033 Stall i_deq in HIGH for 5 cycles -> o_data holds second value; on release, next word's first element follows with no bubble.
REQ-034 Assert i_rst_n=0 in LOW with 3 words buffered -> o_empty=1 and o_data=0 immediately; after release, no stale element appears.

Source files
------------

// File: rtl/decoupler.sv
// Decoupler: buffers coupled {second, first} words in a circular FIFO and presents them as an element stream.
// Optional: DECOUPLER_TERM_COUNT_EN adds o_term_count, a wrapping count of dequeued zero elements.
module decoupler #(
   parameter int P_WIDTH = 32,
   parameter int P_DEPTH = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [2*P_WIDTH-1:0] i_data,
   input  logic                 i_enq,
   output logic                 o_full,
   output logic [P_WIDTH-1:0]   o_data,
   input  logic                 i_deq,
   output logic                 o_empty
`ifdef DECOUPLER_TERM_COUNT_EN
   ,
   output logic [15:0]          o_term_count
`endif
);

   localparam int A = $clog2(P_DEPTH);
   localparam logic [A:0] PTR_ONE = (A + 1)'(1);

   typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

   logic [2*P_WIDTH-1:0] mem [P_DEPTH];
   logic [A:0]           wr_ptr, rd_ptr;
   logic                 buf_empty, buf_full, wr_en, pop;
   logic [2*P_WIDTH-1:0] rd_word, hold;
   state_t               state;

   assign buf_empty = (wr_ptr == rd_ptr);
   // Same index with opposite wrap bits means the writer is a full lap ahead.
   assign buf_full  = (wr_ptr == {~rd_ptr[A], rd_ptr[A-1:0]});
   assign o_full    = buf_full;
   assign rd_word   = mem[rd_ptr[A-1:0]];

   // A write into a full buffer is dropped even if a pop frees a slot on the same edge.
   assign wr_en = i_enq && !buf_full;

   always_comb begin
      pop = 1'b0;
      if (!buf_empty) begin
         unique case (state)
            IDLE:    pop = 1'b1;
            LOW:     pop = i_deq && (hold[P_WIDTH-1:0] == '0);
            HIGH:    pop = i_deq;
            default: pop = 1'b0;
         endcase
      end
   end

   // NOTE: storage array has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge i_clk) begin
      if (wr_en) mem[wr_ptr[A-1:0]] <= i_data;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state   <= IDLE;
         hold    <= '0;
         o_data  <= '0;
         o_empty <= 1'b1;
      end else if (pop) begin
         state   <= LOW;
         hold    <= rd_word;
         o_data  <= rd_word[P_WIDTH-1:0];
         o_empty <= 1'b0;
      end else begin
         unique case (state)
            LOW: if (i_deq) begin
               if (hold[P_WIDTH-1:0] != '0) begin
                  state  <= HIGH;
                  o_data <= hold[2*P_WIDTH-1:P_WIDTH];
               end else begin
                  state   <= IDLE;
                  o_data  <= '0;
                  o_empty <= 1'b1;
               end
            end
            HIGH: if (i_deq) begin
               state   <= IDLE;
               o_data  <= '0;
               o_empty <= 1'b1;
            end
            default: begin
               state   <= IDLE;
               o_data  <= '0;
               o_empty <= 1'b1;
            end
         endcase
      end
   end

`ifdef DECOUPLER_TERM_COUNT_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         o_term_count <= '0;
      else if (i_deq && !o_empty && (o_data == '0))
         o_term_count <= o_term_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_decoupler.sv
// Directed bench for decoupler: a vector table for the basic streams, hand sequences for fill/wrap,
// full-buffer collisions and mid-word reset.
module tb_decoupler;

   localparam int W = 8;
   localparam int D = 4;

   logic           i_clk = 1'b0;
   logic           i_rst_n = 1'b0;
   logic [2*W-1:0] i_data = '0;
   logic           i_enq = 1'b0;
   logic           i_deq = 1'b0;
   logic           o_full, o_empty;
   logic [W-1:0]   o_data;
`ifdef DECOUPLER_TERM_COUNT_EN
   logic [15:0]    o_term_count;
`endif

   decoupler #(.P_WIDTH(W), .P_DEPTH(D)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_data  (i_data),
      .i_enq   (i_enq),
      .o_full  (o_full),
      .o_data  (o_data),
      .i_deq   (i_deq),
      .o_empty (o_empty)
`ifdef DECOUPLER_TERM_COUNT_EN
      ,
      .o_term_count (o_term_count)
`endif
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic           enq;
      logic [2*W-1:0] data;
      logic           deq;
      logic [W-1:0]   exp_data;
      logic           exp_empty;
      logic           exp_full;
   } vec_t;

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [W-1:0] d, input logic e, input logic f);
      check({tag, ".data"},  32'(o_data),  32'(d));
      check({tag, ".empty"}, 32'(o_empty), 32'(e));
      check({tag, ".full"},  32'(o_full),  32'(f));
   endtask

   function automatic vec_t mk(logic enq, logic [2*W-1:0] data, logic deq,
                               logic [W-1:0] ed, logic ee, logic ef);
      vec_t v;
      v.enq = enq; v.data = data; v.deq = deq;
      v.exp_data = ed; v.exp_empty = ee; v.exp_full = ef;
      return v;
   endfunction

   task automatic enq_word(input logic [2*W-1:0] w);
      i_enq  = 1'b1;
      i_data = w;
      step();
      i_enq  = 1'b0;
   endtask

   vec_t vecs[20];
   logic [W-1:0] exp_q[$];

   initial begin
      // Basic stream, zero terminator, stall in HIGH (one vector per edge).
      vecs[0]  = mk(1, 16'h0201, 1, 8'h00, 1, 0);
      vecs[1]  = mk(0, 16'h0000, 1, 8'h01, 0, 0);
      vecs[2]  = mk(0, 16'h0000, 1, 8'h02, 0, 0);
      vecs[3]  = mk(0, 16'h0000, 1, 8'h00, 1, 0);
      vecs[4]  = mk(1, 16'h0500, 1, 8'h00, 1, 0);
      vecs[5]  = mk(1, 16'h0403, 1, 8'h00, 0, 0);
      vecs[6]  = mk(0, 16'h0000, 1, 8'h03, 0, 0);
      vecs[7]  = mk(0, 16'h0000, 1, 8'h04, 0, 0);
      vecs[8]  = mk(0, 16'h0000, 1, 8'h00, 1, 0);
      vecs[9]  = mk(1, 16'h1211, 0, 8'h00, 1, 0);
      vecs[10] = mk(1, 16'h1413, 0, 8'h11, 0, 0);
      vecs[11] = mk(0, 16'h0000, 1, 8'h12, 0, 0);
      for (int i = 12; i < 17; i++) vecs[i] = mk(0, 16'h0000, 0, 8'h12, 0, 0);
      vecs[17] = mk(0, 16'h0000, 1, 8'h13, 0, 0);
      vecs[18] = mk(0, 16'h0000, 1, 8'h14, 0, 0);
      vecs[19] = mk(0, 16'h0000, 1, 8'h00, 1, 0);

      // Reset state.
      #12;
      check_out("reset", 8'h00, 1, 0);
      #10 i_rst_n = 1'b1;   // released mid-cycle; vector 0 enqueues on the next edge

      for (int i = 0; i < 20; i++) begin
         i_enq  = vecs[i].enq;
         i_data = vecs[i].data;
         i_deq  = vecs[i].deq;
         step();
         check_out($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_empty, vecs[i].exp_full);
`ifdef DECOUPLER_TERM_COUNT_EN
         if (i == 8) check("term_count", 32'(o_term_count), 32'd1);
`endif
      end
      i_enq = 1'b0;
      i_deq = 1'b0;

      // Overfill with deq low: word 0 lands in the hold register, four more fill the buffer, word 5 dropped.
      for (int i = 0; i < D + 2; i++) begin
         enq_word({8'(8'h80 + i), 8'(i + 1)});
         check($sformatf("fill%0d.full", i), 32'(o_full), 32'(i >= D));
      end
      exp_q = {};
      for (int i = 0; i <= D; i++) begin
         exp_q.push_back(8'(i + 1));
         exp_q.push_back(8'(8'h80 + i));
      end
      i_deq = 1'b1;
      foreach (exp_q[k]) begin
         check($sformatf("wrap%0d.data", k), 32'(o_data), 32'(exp_q[k]));
         step();
      end
      check("wrap.end_empty", 32'(o_empty), 32'd1);
      i_deq = 1'b0;

      // Full buffer: enq colliding with the HIGH pop must be dropped.
      for (int i = 0; i <= D; i++) enq_word({8'(8'h31 + i), 8'(8'h21 + i)});
      check("coll.full_before", 32'(o_full), 32'd1);
      i_deq = 1'b1;
      step();
      check("coll.high", 32'(o_data), 32'h31);
      check("coll.full_in_high", 32'(o_full), 32'd1);
      i_enq  = 1'b1;
      i_data = 16'h6666;
      step();
      i_enq = 1'b0;
      check("coll.full_after", 32'(o_full), 32'd0);
      exp_q = {};
      for (int i = 1; i <= D; i++) begin
         exp_q.push_back(8'(8'h21 + i));
         exp_q.push_back(8'(8'h31 + i));
      end
      foreach (exp_q[k]) begin
         check($sformatf("coll%0d.data", k), 32'(o_data), 32'(exp_q[k]));
         step();
      end
      check("coll.end_empty", 32'(o_empty), 32'd1);
      i_deq = 1'b0;

      // Reset while presenting LOW with three words buffered.
      for (int i = 0; i < 4; i++) enq_word({8'(8'h51 + i), 8'(8'h41 + i)});
      check("prerst.data", 32'(o_data), 32'h41);
      #2 i_rst_n = 1'b0;
      #1;
      check_out("midrst", 8'h00, 1, 0);
      step();
      #3 i_rst_n = 1'b1;
      i_deq = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out($sformatf("postrst%0d", i), 8'h00, 1, 0);
      end
`ifdef DECOUPLER_TERM_COUNT_EN
      check("term_count.rst", 32'(o_term_count), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
